seq_detect_logger: RTL
======================

Name: seq_detect_logger

Overview:
- Sits directly downstream of the Mealy overlapping sequence detector and consumes its per-bit `detected` strobe.
- Tracks the serial bit position of the stream, counts detections, and records the bit position of each detection in a small FIFO.
- A host or testbench drains the FIFO with a read handshake.
- Gives the detector chain a checkable event log instead of a bare one-cycle pulse.

Parameters:
- POS_W, 8: width of the bit-position counter and of each logged entry.
- CNT_W, 8: width of the saturating detection counter.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- bit_valid  input  1  high for one cycle per serial bit presented to the detector.
- det  input  1  detector output; sampled only when bit_valid=1.
- clr  input  1  synchronous clear of all log state.
- rd_en  input  1  pop request.
- rd_data  output  POS_W  bit position of the popped event.
- rd_valid  output  1  one-cycle strobe; rd_data is valid.
- fifo_empty  output  1  no stored events.
- fifo_full  output  1  DEPTH events stored.
- evt_count  output  CNT_W  detections seen since reset/clr; saturating.
- overflow  output  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (rstn=0, asynchronous):
  - Bit-position counter pos=0, FIFO pointers=0, rd_data=0, rd_valid=0, fifo_empty=1, fifo_full=0, evt_count=0, overflow=0.
  - Takes effect mid-operation; any in-flight pop is abandoned.
- Bit counting:
  - On each bit_valid=1 cycle, pos increments by 1 modulo 2^POS_W (wraps 255->0 at default).
  - pos is 0-based: the first bit after reset/clr is position 0.
- Event capture:
  - An event is det=1 AND bit_valid=1 in the same cycle. det with bit_valid=0 is ignored.
  - The logged value is the pos of the completing bit, i.e. the value before this cycle's increment.
  - evt_count increments on every event; it holds at 2^CNT_W-1 and never wraps.
  - evt_count counts dropped events too.
- Push rules:
  - Not full: the event is written at the write pointer next edge.
  - Full and rd_en=1 in the same cycle: pop and push both succeed; occupancy is unchanged.
  - Full and no pop: the event is dropped and overflow sets to 1 (sticky until rstn or clr).
- Pop rules:
  - rd_en=1 with the FIFO non-empty: rd_data is registered with the head entry at the next edge, and rd_valid=1 for exactly that one cycle.
  - rd_en=1 with the FIFO empty: ignored; rd_valid stays 0 and rd_data holds its last value.
  - Empty with simultaneous push and rd_en: the pop is ignored (no fall-through), the push is stored, and fifo_empty deasserts next cycle.
- Flags:
  - fifo_empty and fifo_full are registered from an occupancy count (0..DEPTH).
  - Both update on the same edge as the push/pop.
  - Latency from event to fifo_empty=0 is 1 cycle.
- clr (synchronous, highest priority after reset):
  - Same cycle effect as reset on the next edge, except rd_data holds its value.
  - Any same-cycle event or pop is discarded.
- Pointers are log2(DEPTH) bits and wrap naturally. The occupancy counter is log2(DEPTH)+1 bits.
- No combinational path from inputs to outputs.

Test Plan:
- Stream 16'b1101_0110_1011_0111 MSB-first, one bit_valid per 10 ns, with a live detector driving det, then pop until empty:
  - evt_count=3, overflow=0.
  - Pops return rd_data 6, 11, 14 in order, each with a single-cycle rd_valid.
  - fifo_empty=1 after the third pop.
- det held high with bit_valid=0 for 5 cycles -> evt_count=0, fifo_empty=1.
- 6 events, no reads, DEPTH=4:
  - fifo_full=1 after the 4th event, overflow=1 after the 5th, evt_count=6.
  - Pops return only the first 4 positions.
- FIFO full, event and rd_en in the same cycle:
  - The oldest entry pops with rd_valid=1 and the new position is stored.
  - fifo_full stays 1 and overflow stays 0.
- 300 bit_valid cycles with det=1 only on bits 255 and 256 -> logged positions 255 then 0 (wrap).
- Mid-stream cases:
  - clr asserted in the same cycle as an event -> evt_count=0, fifo_empty=1, overflow=0, pos restarts at 0.
  - Separately, rstn pulsed low mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/seq_detect_logger.sv
// seq_detect_logger
// Consumes the per-bit strobe of a serial sequence detector. It tracks the
// bit position of the stream, counts detections with a saturating counter,
// and logs the position of each detection in a small FIFO. A host drains the
// FIFO through a registered read port.
module seq_detect_logger #(
  parameter int POS_W = 8,  // bit-position counter / log entry width
  parameter int CNT_W = 8,  // saturating detection counter width
  parameter int DEPTH = 4   // FIFO entries, power of two, >= 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             bit_valid,
  input  logic             det,
  input  logic             clr,
  input  logic             rd_en,
  output logic [POS_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic [AW:0]      occ_nxt;
  logic             evt;
  logic             pop;
  logic             push;
  logic             drop;

  // Event/push/pop decisions and next occupancy.
  // A full FIFO still accepts an event when the same cycle pops, since the
  // popped slot is the one being overwritten. An empty FIFO never pops, so a
  // simultaneous push lands in storage rather than falling through.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment so
    // no path leaves it unassigned; that is what keeps this block latch-free.
    occ_nxt = occ;
    evt     = bit_valid & det;
    pop     = rd_en & (occ != '0);
    push    = evt & ((occ != OCC_FULL) | pop);
    drop    = evt & ~push;
    if (push && !pop) begin
      occ_nxt = occ + OCC_ONE;
    end else if (pop && !push) begin
      occ_nxt = occ - OCC_ONE;
    end
  end

  // Bit-position counter: 0-based, wraps modulo 2^POS_W.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rstn) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (bit_valid) begin
      pos <= pos + POS_ONE;
    end
  end

  // Log storage: written with the position of the completing bit.
  // NOTE: the storage array has no reset; the pointers and occupancy decide
  // which entries are meaningful, so clearing the array would only add logic.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= pos;
    end
  end

  // Pointers, occupancy and registered empty/full flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      occ        <= occ_nxt;
      fifo_empty <= (occ_nxt == '0);
      fifo_full  <= (occ_nxt == OCC_FULL);
    end
  end

  // Registered read port: rd_data loads on a real pop and otherwise holds,
  // including across clr; rd_valid strobes for the single cycle after a pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (clr) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem[rd_ptr];
      end
    end
  end

  // Saturating event counter (dropped events included) and sticky overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_count <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (evt && (evt_count != CNT_MAX)) begin
        evt_count <= evt_count + CNT_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
